// File: rtl/nrisc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the nRisc fetch and data paths.
// Fixed-latency access with one-cycle ack pulses and a combinational stall to the core.
module nrisc_mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             gnt_data;
    logic             last_data;
    logic             pick_data;

    // On contention the port that did not win last time gets the memory.
    assign pick_data = d_req & (~if_req | ~last_data);

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign busy  = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_data  <= 1'b0;
            last_data <= 1'b1;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state     <= ACCESS;
                        gnt_data  <= pick_data;
                        cnt       <= CNT_W'(MEM_LATENCY - 1);
                        mem_addr  <= pick_data ? d_addr : if_addr;
                        mem_wdata <= (pick_data && d_we) ? d_wdata : '0;
                        mem_we    <= pick_data && d_we;
                        mem_re    <= !(pick_data && d_we);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Writes leave both read registers untouched.
                        if (mem_re) begin
                            if (gnt_data)
                                d_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_rdata;
                        end
                        last_data <= gnt_data;
                        if_ack    <= !gnt_data;
                        d_ack     <= gnt_data;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
